// File: rtl/score_accumulator_pkg.sv
// score_accumulator_pkg: event weights, converter state encoding and streak width shared by the scoring slice.
package score_accumulator_pkg;
   localparam int W_CORRECT = 2;
   localparam int W_BONUS   = 3;
   localparam int W_OFF     = 1;
   localparam int W_WRONG   = 2;
   localparam int STREAK_W  = 4;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
endpackage

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential double-dabble, one LOAD cycle, SCORE_W shift cycles, one DONE cycle.
module score_bcd_conv
   import score_accumulator_pkg::*;
#(
   parameter int SCORE_W = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin,
   output logic               busy,
   output logic               done,
   output logic [11:0]        bcd
);
   localparam int CW = $clog2(SCORE_W + 1);
   conv_state_t state, nstate;
   logic [CW-1:0] cnt;
   logic [SCORE_W+11:0] sr, adj;
   always_ff @(posedge clock)
      state <= reset ? IDLE : nstate;
   always_comb
      nstate = state == IDLE  ? (start ? LOAD : IDLE) :
               state == LOAD  ? SHIFT :
               state == SHIFT ? (cnt == CW'(SCORE_W - 1) ? DONE : SHIFT) :
                                (start ? LOAD : IDLE);
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
   end
   always_comb begin
      adj = sr;
      for (int i = 0; i < 3; i++)
         if (adj[SCORE_W+4*i +: 4] >= 4'd5) adj[SCORE_W+4*i +: 4] = adj[SCORE_W+4*i +: 4] + 4'd3;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         sr  <= '0;
         cnt <= '0;
      end else if (state == LOAD) begin
         sr  <= {12'b0, bin};
         cnt <= '0;
      end else if (state == SHIFT) begin
         sr  <= adj << 1;
         cnt <= cnt + 1'b1;
      end
   end
   assign bcd = sr[SCORE_W+11:SCORE_W];
endmodule

// File: rtl/score_accumulator.sv
// score_accumulator: edge-detected scoring events into a saturating score, hit streak and BCD display digits.
// Optional STREAK_BONUS_EN makes CORRECT worth W_BONUS once the streak reaches STREAK_THRESH.
module score_accumulator
   import score_accumulator_pkg::*;
#(
   parameter int SCORE_W       = 10,
   parameter int MAX_SCORE     = 999,
   parameter int STREAK_THRESH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                correct,
   input  logic                wrong,
   input  logic                off,
   output logic [SCORE_W-1:0]  score,
   output logic [3:0]          dig2,
   output logic [3:0]          dig1,
   output logic [3:0]          dig0,
   output logic                bcd_valid,
   output logic [STREAK_W-1:0] streak
);
   localparam logic signed [SCORE_W+1:0] DC   = (SCORE_W+2)'(W_CORRECT);
   localparam logic signed [SCORE_W+1:0] DB   = (SCORE_W+2)'(W_BONUS);
   localparam logic signed [SCORE_W+1:0] DO   = (SCORE_W+2)'(W_OFF);
   localparam logic signed [SCORE_W+1:0] DW   = (SCORE_W+2)'(W_WRONG);
   localparam logic signed [SCORE_W+1:0] MAXS = (SCORE_W+2)'(MAX_SCORE);
   localparam logic [SCORE_W-1:0]        MAXV = SCORE_W'(MAX_SCORE);
   logic pc, pw, po, ec, ew, eo, bonus, chg, start, busy, done, pending;
   logic signed [SCORE_W+1:0] delta, sum;
   logic [SCORE_W-1:0] nscore;
   logic [STREAK_W-1:0] nstreak;
   logic [11:0] bcd;
`ifdef STREAK_BONUS_EN
   assign bonus = streak >= STREAK_W'(STREAK_THRESH);
`else
   logic unused_thresh;
   assign bonus = 1'b0;
   assign unused_thresh = ^STREAK_THRESH;
`endif
   always_comb begin
      ec = correct & ~pc;
      ew = wrong & ~pw;
      eo = off & ~po;
      delta = (ec ? (bonus ? DB : DC) : '0) + (eo ? DO : '0) - (ew ? DW : '0);
      sum = $signed({2'b00, score}) + delta;
      nscore = sum[SCORE_W+1] ? '0 : sum > MAXS ? MAXV : sum[SCORE_W-1:0];
      nstreak = ew ? '0 : (ec & ~&streak) ? streak + 1'b1 : streak;
      chg = nscore != score;
      // a change landing in DONE reloads directly, so the stale result is never shown
      start = (~busy & chg) | (done & (pending | chg));
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         {pc, pw, po} <= '0;
         score        <= '0;
         streak       <= '0;
         pending      <= 1'b0;
         {dig2, dig1, dig0} <= '0;
      end else begin
         {pc, pw, po} <= {correct, wrong, off};
         score        <= nscore;
         streak       <= nstreak;
         pending      <= start ? 1'b0 : (busy & chg) ? 1'b1 : pending;
         if (done & ~start) {dig2, dig1, dig0} <= bcd;
      end
   end
   assign bcd_valid = ~busy;
   score_bcd_conv #(.SCORE_W(SCORE_W)) u_conv (
      .clock(clock),
      .reset(reset),
      .start(start),
      .bin(score),
      .busy(busy),
      .done(done),
      .bcd(bcd)
   );
endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: random and directed stimulus checked every cycle against a behavioural score/display model.
module tb_score_accumulator;
   localparam int SW = 10;
   logic clk = 0, rst = 1, correct = 0, wrong = 0, off = 0;
   logic [SW-1:0] score;
   logic [3:0] dig2, dig1, dig0, streak;
   logic bcd_valid;
   int passed = 0, total = 0;
   int m_score = 0, m_streak = 0, m_dig = 0, rem = 0;
   bit dirty = 0, mpc = 0, mpw = 0, mpo = 0;
   int lows = 0;
   bit saw1 = 0;

   score_accumulator dut (
      .clock(clk), .reset(rst), .correct(correct), .wrong(wrong), .off(off),
      .score(score), .dig2(dig2), .dig1(dig1), .dig0(dig0),
      .bcd_valid(bcd_valid), .streak(streak)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // behavioural model: score arithmetic, and a display that only refreshes when a full conversion saw no score change
   always @(posedge clk) begin
      int ns, nst, d;
      bit ec, ew, eo, ch;
      if (rst) begin
         m_score <= 0; m_streak <= 0; m_dig <= 0; rem <= 0; dirty <= 0;
         mpc <= 0; mpw <= 0; mpo <= 0;
      end else begin
         ec = correct && !mpc;
         ew = wrong && !mpw;
         eo = off && !mpo;
         d = 0;
`ifdef STREAK_BONUS_EN
         if (ec) d += (m_streak >= 4) ? 3 : 2;
`else
         if (ec) d += 2;
`endif
         if (eo) d += 1;
         if (ew) d -= 2;
         ns = m_score + d;
         if (ns < 0) ns = 0;
         if (ns > 999) ns = 999;
         nst = ew ? 0 : ec ? (m_streak < 15 ? m_streak + 1 : 15) : m_streak;
         ch = ns != m_score;
         if (rem == 0) begin
            if (ch) begin rem <= SW + 2; dirty <= 0; end
         end else if (rem == 1) begin
            if (dirty || ch) begin rem <= SW + 2; dirty <= 0; end
            else begin m_dig <= m_score; rem <= 0; end
         end else begin
            rem <= rem - 1;
            if (ch) dirty <= 1;
         end
         m_score <= ns; m_streak <= nst;
         mpc <= correct; mpw <= wrong; mpo <= off;
      end
   end

   always @(negedge clk) begin
      chk("score", int'(score), m_score);
      chk("streak", int'(streak), m_streak);
      chk("valid", int'(bcd_valid), int'(rem == 0));
      chk("digits", int'(dig2) * 100 + int'(dig1) * 10 + int'(dig0), m_dig);
      lows += !bcd_valid;
      if (dig2 == 0 && dig1 == 0 && dig0 == 1) saw1 = 1;
   end

   task automatic step(input bit c, input bit w, input bit o);
      @(posedge clk) #2;
      correct = c; wrong = w; off = o;
   endtask

   task automatic pulse(input bit c, input bit w, input bit o);
      step(c, w, o);
      step(0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk) #2;
      rst = 1; correct = 0; wrong = 0; off = 0;
      @(posedge clk) #2;
      rst = 0;
   endtask

   initial begin
      idle(2);
      rst = 0;
      @(negedge clk);
      chk("rst_score", int'(score), 0);
      chk("rst_digits", {dig2, dig1, dig0}, 0);
      chk("rst_valid", int'(bcd_valid), 1);
      chk("rst_streak", int'(streak), 0);

      step(1, 0, 0);
      lows = 0;
      repeat (4) step(1, 0, 0);
      idle(16);
      chk("held_score", int'(score), 2);
      chk("held_dig0", int'(dig0), 2);
      chk("held_lowcycles", lows, 12);

      do_reset();
      pulse(0, 0, 1);
      idle(15);
      pulse(0, 1, 0);
      @(negedge clk);
      chk("wrong_floor", int'(score), 0);
      chk("wrong_streak", int'(streak), 0);
      idle(15);
      lows = 0;
      pulse(0, 1, 0);
      idle(15);
      chk("zero_score", int'(score), 0);
      chk("zero_noconv", lows, 0);

      do_reset();
      repeat (3) pulse(1, 0, 0);
      repeat (4) pulse(0, 0, 1);
      idle(15);
      chk("pre_sum", m_score * 100 + m_streak, 1003);
      pulse(1, 1, 1);
      @(negedge clk);
      chk("sim_score", int'(score), 11);
      chk("sim_streak", int'(streak), 0);

      for (int i = 0; i < 1000 && m_score < 996; i++) pulse(1, 0, 0);
      for (int i = 0; i < 10 && m_score < 998; i++) pulse(0, 0, 1);
      idle(15);
      chk("drive_998", int'(score), 998);
      pulse(1, 0, 0);
      idle(15);
      chk("sat_score", int'(score), 999);
      chk("sat_digits", {dig2, dig1, dig0}, 12'h999);
      pulse(0, 0, 1);
      idle(15);
      chk("sat_hold", int'(score), 999);

      do_reset();
      @(negedge clk);
      lows = 0; saw1 = 0;
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      idle(30);
      chk("chain_no1", int'(saw1), 0);
      chk("chain_dig0", int'(dig0), 3);
      chk("chain_lows", lows, 24);

      do_reset();
      repeat (6) pulse(1, 0, 0);
      idle(15);
`ifdef STREAK_BONUS_EN
      chk("six_score", int'(score), 14);
`else
      chk("six_score", int'(score), 12);
`endif
      chk("six_streak", int'(streak), 6);

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk) #2;
         rst = $urandom_range(0, 299) == 0;
         correct = $urandom_range(0, 2) == 0;
         wrong = $urandom_range(0, 4) == 0;
         off = $urandom_range(0, 3) == 0;
         if ((i % 500) > 470) begin correct = 0; wrong = 0; off = 0; end
      end
      idle(30);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
